// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared constants, state type and helpers for the nibble serial adder
//
// Purpose : common definitions for nibble_serial_adder and nibble_add_slice.
// Contents: NIBBLE_W    - width of one slice (bits)
//           nsa_state_t - sequencer states IDLE/RUN
//           nib_count() - number of nibbles in a given operand width
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } nsa_state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// rtl/nibble_serial_adder_slice.sv - combinational 4-bit ripple-carry full-adder slice
//
// Purpose : one nibble of addition; reused every cycle by nibble_serial_adder.
// Ports   : a[3:0], b[3:0] - operand nibbles
//           cin            - carry into bit 0
//           s[3:0]         - sum nibble
//           cout           - carry out of bit 3
module nibble_add_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder computed one nibble per clock through a single slice
//
// Purpose : sequences a 4-bit ripple slice over WIDTH/4 nibbles, LSB nibble first.
// Ports   : clk    - clock, rising edge
//           rst_n  - synchronous active-low reset
//           Start  - begin an operation (sampled only while idle)
//           A, B   - operands, captured on the accepting edge
//           C      - carry-in, captured on the accepting edge
//           Sub    - (NSA_SUB_EN only) 1 = compute A-B, C ignored
//           Busy   - operation in progress
//           Done   - one-cycle pulse: Sum/Carry just updated
//           Sum    - result register
//           Carry  - carry out of the MSB nibble (1 = no borrow when subtracting)
// Macro   : NSA_SUB_EN adds the Sub input and subtraction support.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
`ifdef NSA_SUB_EN
  input  logic             Sub,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  generate
    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  nsa_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             cr_q, cr_d;
  logic [WIDTH-1:0] wk_q, wk_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
  logic                slice_cout;

  assign slice_a = op_a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign slice_b = op_b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  nibble_add_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (cr_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cr_d    = cr_q;
    wk_d    = wk_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          op_a_d  = A;
`ifdef NSA_SUB_EN
          // A - B as A + ~B + 1; carry-out then means "no borrow".
          op_b_d  = Sub ? ~B : B;
          cr_d    = Sub ? 1'b1 : C;
`else
          op_b_d  = B;
          cr_d    = C;
`endif
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        wk_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_s;
        cr_d  = slice_cout;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // wk_d already holds the final nibble, so the full result lands in one edge.
          sum_d   = wk_d;
          carry_d = slice_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cr_q    <= 1'b0;
      wk_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cr_q    <= cr_d;
      wk_q    <= wk_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder (WIDTH=16)
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             Start;
  logic [WIDTH-1:0] A, B;
  logic             C;
  logic             Busy, Done, Carry;
  logic [WIDTH-1:0] Sum;
`ifdef NSA_SUB_EN
  logic             Sub;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
`ifdef NSA_SUB_EN
    .Sub   (Sub),
`endif
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .C     (C),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Carry (Carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_carry;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for Done with a bounded budget; returns edges waited and whether Busy stayed high meanwhile.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!Done && lat < 20) begin
      if (!Busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH-1:0] es, input logic ec);
    int lat;
    bit busy_ok;
    A = a; B = b; C = c; Start = 1'b1;
    tick();
    Start = 1'b0;
    A = 'x; B = 'x; C = 1'bx;
    check({name, " busy_after_start"}, 32'(Busy), 32'd1);
    wait_done(lat, busy_ok);
    check({name, " latency"}, 32'(lat), 32'(LAT));
    check({name, " busy_during_run"}, 32'(busy_ok), 32'd1);
    check({name, " sum"}, 32'(Sum), 32'(es));
    check({name, " carry"}, 32'(Carry), 32'(ec));
    check({name, " busy_at_done"}, 32'(Busy), 32'd0);
    tick();
    check({name, " done_one_cycle"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int done_cnt;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

    rst_n = 1'b0; Start = 1'b0; A = '0; B = '0; C = 1'b0;
`ifdef NSA_SUB_EN
    Sub = 1'b0;
`endif
    tick(); tick();
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset sum", 32'(Sum), 32'd0);
    check("reset carry", 32'(Carry), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_sum, vecs[i].exp_carry);
      tick();
    end

    // Back-to-back: second Start issued in the Done cycle.
    A = 16'hFFFF; B = 16'h0000; C = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(lat, busy_ok);
    check("b2b first sum", 32'(Sum), 32'h0000);
    check("b2b first carry", 32'(Carry), 32'd1);
    A = 16'h000F; B = 16'h0001; C = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("b2b accepted busy", 32'(Busy), 32'd1);
    check("b2b sum holds", 32'(Sum), 32'h0000);
    check("b2b carry holds", 32'(Carry), 32'd1);
    wait_done(lat, busy_ok);
    check("b2b second latency", 32'(lat), 32'(LAT));
    check("b2b second sum", 32'(Sum), 32'h0010);
    check("b2b second carry", 32'(Carry), 32'd0);
    tick();

    // Start held while busy with changing operands is ignored.
    A = 16'h1234; B = 16'h4321; C = 1'b0; Start = 1'b1;
    tick();
    A = 16'hFFFF; B = 16'hFFFF; C = 1'b1;
    tick(); tick();
    Start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (Done) begin
        done_cnt++;
        check("held start sum", 32'(Sum), 32'h5555);
        check("held start carry", 32'(Carry), 32'd0);
      end
      tick();
    end
    check("held start done count", 32'(done_cnt), 32'd1);

    // Reset while idx==2 aborts the operation.
    A = 16'h1234; B = 16'h4321; C = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", 32'(Busy), 32'd0);
    check("abort done", 32'(Done), 32'd0);
    check("abort sum", 32'(Sum), 32'd0);
    check("abort carry", 32'(Carry), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (Done) done_cnt++;
      tick();
    end
    check("abort no done", 32'(done_cnt), 32'd0);
    run_op("after abort", 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0);
    tick();

`ifdef NSA_SUB_EN
    Sub = 1'b1;
    run_op("sub 5-7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    tick();
    Sub = 1'b1;
    run_op("sub 7-5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    tick();
    Sub = 1'b0;
    run_op("sub off add", 16'h0007, 16'h0005, 1'b1, 16'h000D, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential multi-word adder that produces a WIDTH-bit sum 4 bits per clock.
- Each cycle it feeds one 4-bit slice adder with operand nibbles and a registered carry, then captures that slice's Sum and Carry.
- It is the sequencing stage around the 4-bit ripple slice. Wide additions reuse one slice instead of replicating WIDTH/4 slices.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and ≥4; any other value is an elaboration error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Start  in  1  request to begin an operation. Sampled only in IDLE.
- A  in  WIDTH  operand A. Captured on an accepted Start.
- B  in  WIDTH  operand B. Captured on an accepted Start.
- C  in  1  carry-in. Captured on an accepted Start.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse marking that Sum/Carry have just been updated.
- Sum  out  WIDTH  result register.
- Carry  out  1  carry-out of the MSB nibble.

Behaviour:
- Interface reset: clock port is clk. Reset port is rst_n, synchronous, active-low; it is sampled only at the rising edge of clk.
- Reset values: Busy=0, Done=0, Sum=0, Carry=0, state=IDLE, nibble index=0, carry register=0, operand registers=0.
- NIB = WIDTH/4. The nibble index is a counter of width clog2(NIB), minimum 1 bit.
- State IDLE:
  - Start=1 at an edge latches A, B and C into opA, opB and cr.
  - The same edge sets idx=0 and Busy=1, and moves the FSM to RUN.
- State RUN, at each edge:
  - slice inputs are opA[4*idx+:4], opB[4*idx+:4] and cr;
  - the slice Sum is written to wk[4*idx+:4], and the slice Carry is written to cr;
  - idx increments.
- Last nibble (edge with idx==NIB-1):
  - Sum<=wk with the final nibble merged in, and Carry<=slice Carry;
  - Done<=1 and Busy<=0;
  - FSM goes to IDLE.
- Done is high for exactly one cycle. Latency is NIB edges from the Start-accepting edge to Done high; for WIDTH=16, Done rises 4 cycles after Start is sampled.
- Sum and Carry change only on the completion edge and hold their values otherwise, including during the next operation.
- Start while Busy=1 is ignored, with no queuing.
- Start in the cycle where Done=1 is accepted, since the FSM is already in IDLE. This gives back-to-back throughput of one result per NIB+1 cycles.
- Inputs A, B and C are don't-care after the accepting edge.
- rst_n=0 during RUN aborts the operation: no Done, and Sum/Carry are forced to 0.
- The slice is purely combinational: Sum = a^b^cin per bit, with ripple carry majority(a,b,cin) across its 4 bits.

Optional Feature:
- Macro NSA_SUB_EN.
- Defined: adds input port Sub (1 bit), captured with Start.
  - Sub=1 computes A−B: opB<=~B, cr<=1, and C is ignored.
  - Carry=1 means no borrow.
  - Sub=0 behaves exactly as undefined.
- Undefined: no Sub port; the block only adds.

Decomposition:
- Package nsa_pkg holds:
  - NIBBLE_W=4;
  - state typedef nsa_state_t {IDLE, RUN};
  - function nib_count(width) returning width/4.
- Sub-module nibble_add_slice: combinational 4-bit ripple full-adder with ports a[3:0], b[3:0], cin, s[3:0], cout. It is instantiated once.
- Everything else (FSM, counters, registers) stays in nibble_serial_adder.

Test Plan:
- WIDTH=16, A=0x1234, B=0x4321, C=0, Start 1 cycle -> Busy high 4 cycles; Done pulses once 4 cycles after Start; Sum=0x5555, Carry=0.
- A=0xFFFF, B=0x0001, C=0 -> carry ripples through all nibbles; Sum=0x0000, Carry=1.
- A=0xFFFF, B=0x0000, C=1 -> Sum=0x0000, Carry=1. Then A=0x000F, B=0x0001, C=0 started in the Done cycle -> accepted back-to-back; Sum=0x0010, Carry=0 four cycles later.
- Start held high while Busy with different operands -> ignored; first result 0x5555 delivered unchanged, and exactly one Done per accepted Start.
- rst_n low for 1 cycle at idx=2 -> no Done; Busy=0, Sum=0, Carry=0. A new Start completes correctly.
- NSA_SUB_EN defined, Sub=1, A=0x0005, B=0x0007 -> Sum=0xFFFE, Carry=0. With A=0x0007, B=0x0005 -> Sum=0x0002, Carry=1.
